hamming_secded_decoder: RTL

- Parametrised, pipelined extended-Hamming (SECDED) decoder.
- Accepts one codeword per cycle over a valid/ready handshake.
- Corrects single-bit errors, detects double-bit errors, and keeps saturating event counters.
- Sits between the channel/memory read path and the consumer, as the generalised successor of the fixed 7-to-4 combinational decoder.

---
 rtl/hamming_pkg.sv | 39 +++
 rtl/hamming_syndrome.sv | 28 ++
 rtl/hamming_secded_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// hamming_pkg : shared SECDED sizing helpers, position map and status type
// Revision    : 1.0
// ============================================================================
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN     = 2'd0,
        CORRECTED = 2'd1,
        UNCORR    = 2'd2
    } status_e;

    // Smallest r with 2^r >= data_w + r + 1; the satisfying set is upward-closed.
    function automatic int calc_par_w(input int data_w);
        int r;
        r = 30;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) >= data_w + i + 1) r = i;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data index of a non-check Hamming position: positions below it minus check bits.
    function automatic int pos_to_data_idx(input int pos);
        int n_chk;
        n_chk = 0;
        for (int p = 0; p < 31; p++) begin
            if ((1 << p) <= pos) n_chk++;
        end
        return pos - 1 - n_chk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome.sv
`default_nettype none
// ============================================================================
// hamming_syndrome : combinational Hamming syndrome and overall parity
// Revision         : 1.0
// ============================================================================
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic [CW_W-1:0]  cw_i,
    output logic [PAR_W-1:0] syndrome_o,
    output logic             parity_o
);

    always_comb begin
        syndrome_o = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (cw_i[k]) syndrome_o = syndrome_o ^ PAR_W'(k);
        end
    end

    assign parity_o = ^cw_i;

endmodule
`default_nettype wire

// File: rtl/hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// hamming_secded_decoder : two-stage SECDED decoder with valid/ready and counters
// Revision               : 1.0
// ============================================================================
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corrected,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CW_W - 1);

    logic [PAR_W-1:0]  syn_w;
    logic              par_w;

    logic              s1_valid_q;
    logic [CW_W-1:0]   s1_cw_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;
    logic              s1_cen_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [PAR_W-1:0]  out_syndrome_q;
    logic              out_corrected_q;
    logic              out_uncorr_q;

    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_unc_q,  cnt_unc_d;

    status_e           status_d;
    logic              flip_d;
    logic [CW_W-1:0]   fixed_cw_d;
    logic [DATA_W-1:0] data_d;
    logic              advance;
    logic              xfer_out;

    hamming_syndrome #(
        .DATA_W(DATA_W)
    ) u_syndrome (
        .cw_i      (in_cw),
        .syndrome_o(syn_w),
        .parity_o  (par_w)
    );

    // Only a full, unaccepted output register stalls; the whole pipe moves together.
    assign advance  = ~(out_valid_q & ~out_ready);
    assign in_ready = advance;
    assign xfer_out = out_valid_q & out_ready;

    always_comb begin
        status_d = CLEAN;
        flip_d   = 1'b0;
        if (s1_par_q) begin
            if (s1_syn_q > MAX_POS) begin
                status_d = UNCORR;
            end else begin
                status_d = s1_cen_q ? CORRECTED : UNCORR;
                flip_d   = s1_cen_q && (s1_syn_q != '0);
            end
        end else if (s1_syn_q != '0) begin
            status_d = UNCORR;
        end
    end

    assign fixed_cw_d = flip_d ? (s1_cw_q ^ (CW_W'(1) << s1_syn_q)) : s1_cw_q;

    always_comb begin
        data_d = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (!is_pow2(k)) data_d[pos_to_data_idx(k)] = fixed_cw_d[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_cw_q         <= '0;
            s1_syn_q        <= '0;
            s1_par_q        <= 1'b0;
            s1_cen_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_syndrome_q  <= '0;
            out_corrected_q <= 1'b0;
            out_uncorr_q    <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            if (in_valid) begin
                s1_cw_q  <= in_cw;
                s1_syn_q <= syn_w;
                s1_par_q <= par_w;
                s1_cen_q <= correct_en;
            end
            if (s1_valid_q) begin
                out_data_q      <= data_d;
                out_syndrome_q  <= s1_syn_q;
                out_corrected_q <= (status_d == CORRECTED);
                out_uncorr_q    <= (status_d == UNCORR);
            end
        end
    end

    // A clear that coincides with a counted beat leaves that beat counted.
    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        if (cnt_clr) begin
            cnt_corr_d = (xfer_out && out_corrected_q) ? CNT_W'(1) : '0;
            cnt_unc_d  = (xfer_out && out_uncorr_q)    ? CNT_W'(1) : '0;
        end else begin
            if (xfer_out && out_corrected_q && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + CNT_W'(1);
            if (xfer_out && out_uncorr_q    && (cnt_unc_q  != '1)) cnt_unc_d  = cnt_unc_q  + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else begin
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_syndrome  = out_syndrome_q;
    assign out_corrected = out_corrected_q;
    assign out_uncorr    = out_uncorr_q;
    assign cnt_corrected = cnt_corr_q;
    assign cnt_uncorr    = cnt_unc_q;

endmodule
`default_nettype wire
